// File: rtl/param_bus_register.sv
// param_bus_register: WIDTH-bit BasComp register loaded from the common bus, with inc/dec/clr,
// zero and carry/borrow status, and a sticky command-conflict flag. Optional macro: SAT_EN.
module param_bus_register #(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          BUS_WIDTH = 16,
  parameter logic [BUS_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  input  logic                 err_clr,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]     out_data,
  output logic                 zero,
  output logic                 carry,
  output logic                 err
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] NIL  = '0;
  localparam logic [WIDTH-1:0] INIT = RESET_VAL[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > BUS_WIDTH) begin : g_bad_width
    $error("param_bus_register: WIDTH must be within 1..BUS_WIDTH");
  end

  // Only the low WIDTH bus bits are architecturally visible to this register.
  if (BUS_WIDTH > WIDTH) begin : g_bus_upper
    logic unused_bus_upper;
    assign unused_bus_upper = ^in_data[BUS_WIDTH-1:WIDTH];
  end

  // Increment with overflow flag in the MSB; the result either wraps or sticks at all-ones.
  function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    if (v == ONES) begin
`ifdef SAT_EN
      r = {1'b1, ONES};
`else
      r = {1'b1, NIL};
`endif
    end else begin
      r = {1'b0, v + WIDTH'(1'b1)};
    end
    return r;
  endfunction

  // Decrement with borrow flag in the MSB; the result either wraps or sticks at zero.
  function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    if (v == NIL) begin
`ifdef SAT_EN
      r = {1'b1, NIL};
`else
      r = {1'b1, ONES};
`endif
    end else begin
      r = {1'b0, v - WIDTH'(1'b1)};
    end
    return r;
  endfunction

  logic [2:0]       cmd_cnt_p0;
  logic             conflict_p0;
  logic [WIDTH-1:0] data_p0;
  logic             carry_p0;
  logic             err_p0;
  logic [WIDTH:0]   up_p0;
  logic [WIDTH:0]   down_p0;

  // Stage p0: decode the command set and form next-state values.
  always_comb begin
    cmd_cnt_p0  = {2'b00, load} + {2'b00, inc} + {2'b00, dec} + {2'b00, clr};
    conflict_p0 = (cmd_cnt_p0 > 3'd1);
    up_p0       = step_up(out_data);
    down_p0     = step_down(out_data);
    data_p0     = out_data;
    carry_p0    = 1'b0;

    // With no priority among commands, a conflict simply leaves the contents untouched.
    if (cmd_cnt_p0 == 3'd1) begin
      if (load) begin
        data_p0 = in_data[WIDTH-1:0];
      end else if (clr) begin
        data_p0 = NIL;
      end else if (inc) begin
        data_p0  = up_p0[WIDTH-1:0];
        carry_p0 = up_p0[WIDTH];
      end else begin
        data_p0  = down_p0[WIDTH-1:0];
        carry_p0 = down_p0[WIDTH];
      end
    end

    // A fresh conflict outranks a simultaneous clear request.
    if (conflict_p0) begin
      err_p0 = 1'b1;
    end else if (err_clr) begin
      err_p0 = 1'b0;
    end else begin
      err_p0 = err;
    end
  end

  // Stage p1: architectural register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= INIT;
      carry    <= 1'b0;
      err      <= 1'b0;
    end else begin
      out_data <= data_p0;
      carry    <= carry_p0;
      err      <= err_p0;
    end
  end

  assign zero = (out_data == NIL);

endmodule
